gray_seq_ctrl: RTL and testbench

GRAY_SEQ_CTRL -- requirements
Module: gray_seq_ctrl

---
 rtl/gray_seq_ctrl.sv | 159 +++++++++++++++
 tb/tb_gray_seq_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gray_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | gray_seq_ctrl: handshaked Gray/binary sequence generator (IDLE/RUN/DONE).  |
// | Optional adjacency checker compiled in with macro GRAY_SEQ_CHECK_EN.       |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module gray_seq_ctrl #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             dir,
    input  logic [WIDTH-1:0] start_val,
    input  logic [WIDTH-1:0] len,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_gray,
    output logic [WIDTH-1:0] out_bin,
    output logic             busy,
    output logic             done,
    output logic             wrap,
    output logic             err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE_VAL  = WIDTH'(1);
    localparam logic [WIDTH:0]   FULL_LEN = {1'b1, {WIDTH{1'b0}}};

    state_t           r_state;
    logic             r_dir;
    logic [WIDTH:0]   r_total;
    logic [WIDTH:0]   r_cnt;

    logic             w_accept;
    logic [WIDTH-1:0] w_next_bin;
    logic [WIDTH:0]   w_start_total;

    function automatic logic [WIDTH-1:0] gray_of(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic wrap_of(input logic [WIDTH-1:0] b, input logic d);
        return d ? (b == '0) : (b == MAX_VAL);
    endfunction

    assign w_accept      = out_valid && out_ready;
    assign w_next_bin    = r_dir ? (out_bin - ONE_VAL) : (out_bin + ONE_VAL);
    // len of zero encodes a full 2^WIDTH-beat cycle, hence the extra counter bit
    assign w_start_total = (len == '0) ? FULL_LEN : {1'b0, len};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_dir     <= 1'b0;
            r_total   <= '0;
            r_cnt     <= '0;
            out_valid <= 1'b0;
            out_bin   <= '0;
            out_gray  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            wrap      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    done <= 1'b0;
                    if (start && !abort) begin
                        r_state   <= RUN;
                        r_dir     <= dir;
                        r_total   <= w_start_total;
                        r_cnt     <= (WIDTH+1)'(1);
                        out_valid <= 1'b1;
                        out_bin   <= start_val;
                        out_gray  <= gray_of(start_val);
                        wrap      <= wrap_of(start_val, dir);
                        busy      <= 1'b1;
                    end
                end
                RUN: begin
                    if (abort) begin
                        r_state   <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b0;
                        wrap      <= 1'b0;
                    end else if (w_accept) begin
                        if (r_cnt == r_total) begin
                            r_state   <= DONE;
                            out_valid <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            wrap      <= 1'b0;
                        end else begin
                            r_cnt    <= r_cnt + 1'b1;
                            out_bin  <= w_next_bin;
                            out_gray <= gray_of(w_next_bin);
                            wrap     <= wrap_of(w_next_bin, r_dir);
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    done    <= 1'b0;
                end
                default: begin
                    r_state   <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    wrap      <= 1'b0;
                end
            endcase
        end
    end

`ifdef GRAY_SEQ_CHECK_EN
    logic [WIDTH-1:0] r_prev_gray;
    logic             r_have_prev;

    function automatic logic single_bit(input logic [WIDTH-1:0] v);
        int cnt;
        cnt = 0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt = cnt + int'(v[i]);
        end
        return (cnt == 1);
    endfunction

    // Only consecutive accepted beats of one sequence are compared
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_prev_gray <= '0;
            r_have_prev <= 1'b0;
            err         <= 1'b0;
        end else if (r_state == IDLE && start && !abort) begin
            r_have_prev <= 1'b0;
            err         <= 1'b0;
        end else if (r_state == RUN && !abort && w_accept) begin
            if (r_have_prev && !single_bit(r_prev_gray ^ out_gray)) begin
                err <= 1'b1;
            end
            r_prev_gray <= out_gray;
            r_have_prev <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_gray_seq_ctrl.sv
`default_nettype none
// Scoreboard bench for gray_seq_ctrl (WIDTH=3): directed and random sequences.
module tb_gray_seq_ctrl;

    localparam int W = 3;
    localparam int N = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic         abort;
    logic         dir;
    logic [W-1:0] start_val;
    logic [W-1:0] len;
    logic         out_ready;
    logic         out_valid;
    logic [W-1:0] out_gray;
    logic [W-1:0] out_bin;
    logic         busy;
    logic         done;
    logic         wrap;
    logic         err;

    typedef struct {
        bit is_done;
        int bin;
        int gray;
        bit wrap;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    bit   mon_en = 1'b1;

    gray_seq_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .dir(dir),
        .start_val(start_val), .len(len), .out_ready(out_ready),
        .out_valid(out_valid), .out_gray(out_gray), .out_bin(out_bin),
        .busy(busy), .done(done), .wrap(wrap), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: k-th beat is start +/- k mod 2^W; Gray is b xor (b >> 1)
    task automatic push_expected(input int sv, input bit d, input int nbeats, input bit with_done);
        exp_t e;
        for (int k = 0; k < nbeats; k++) begin
            e.is_done = 1'b0;
            e.bin     = d ? ((sv - k) % N + N) % N : (sv + k) % N;
            e.gray    = e.bin ^ (e.bin >> 1);
            e.wrap    = d ? (e.bin == 0) : (e.bin == N - 1);
            q.push_back(e);
        end
        if (with_done) begin
            e = '{is_done: 1'b1, bin: 0, gray: 0, wrap: 1'b0};
            q.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        if (rst && mon_en) begin
            if (out_valid && !abort) begin
                if (q.size() == 0 || q[0].is_done) begin
                    chk("beat_unexpected", 1, 0);
                end else begin
                    chk("beat_bin", int'(out_bin), q[0].bin);
                    chk("beat_gray", int'(out_gray), q[0].gray);
                    chk("beat_wrap", int'(wrap), int'(q[0].wrap));
                    if (out_ready) void'(q.pop_front());
                end
            end
            if (done) begin
                if (q.size() == 0 || !q[0].is_done) begin
                    chk("done_unexpected", 1, 0);
                end else begin
                    chk("done_valid_low", int'(out_valid), 0);
                    void'(q.pop_front());
                end
            end
        end
    end

    task automatic run_seq(input int sv, input int ln, input bit d,
                           input int stall_beat, input int stall_cyc,
                           input int abort_beat, input int start_beat,
                           input int rst_beat, input bit rnd);
        int n      = (ln == 0) ? N : ln;
        int acc    = 0;
        int stalls = 0;
        int cyc    = 0;
        int beat;
        bit fin    = 1'b0;
        int nexp   = (abort_beat > 0) ? abort_beat - 1 : ((rst_beat > 0) ? rst_beat - 1 : n);

        push_expected(sv, d, nexp, (abort_beat == 0 && rst_beat == 0));
        start     = 1'b1;
        dir       = d;
        start_val = W'(sv);
        len       = W'(ln);
        @(posedge clk); #1;
        start     = 1'b0;
        dir       = 1'($urandom_range(0, 1));
        start_val = W'($urandom_range(0, N - 1));
        len       = W'($urandom_range(0, N - 1));
        chk("first_valid", int'(out_valid), 1);
        chk("first_bin", int'(out_bin), sv);

        while (!fin && cyc < 100) begin
            cyc++;
            beat      = acc + 1;
            chk("busy_run", int'(busy), 1);
            out_ready = 1'b1;
            abort     = 1'b0;
            start     = 1'b0;
            if (rnd) out_ready = ($urandom_range(0, 3) != 0);
            if (beat == stall_beat && stalls < stall_cyc) begin
                out_ready = 1'b0;
                stalls++;
            end
            if (beat == start_beat) begin
                start     = 1'b1;
                start_val = W'($urandom_range(0, N - 1));
            end
            if (beat == abort_beat) begin
                abort     = 1'b1;
                out_ready = 1'($urandom_range(0, 1));
                fin       = 1'b1;
            end else if (beat == rst_beat) begin
                rst = 1'b0;
                #1;
                chk("rst_valid", int'(out_valid), 0);
                chk("rst_busy", int'(busy), 0);
                chk("rst_bin", int'(out_bin), 0);
                chk("rst_gray", int'(out_gray), 0);
                chk("rst_wrap", int'(wrap), 0);
                fin = 1'b1;
            end else if (out_valid && out_ready) begin
                acc++;
                if (acc == n) fin = 1'b1;
            end
            @(posedge clk); #1;
        end
        if (!fin) chk("seq_timeout", 1, 0);
        abort = 1'b0;
        start = 1'b0;

        if (abort_beat > 0) begin
            chk("abort_valid", int'(out_valid), 0);
            chk("abort_busy", int'(busy), 0);
            chk("abort_done", int'(done), 0);
            @(posedge clk); #1;
            chk("abort_done_after", int'(done), 0);
        end else if (rst_beat > 0) begin
            rst = 1'b1;
            @(posedge clk); #1;
            chk("post_rst_idle", int'(out_valid), 0);
        end else begin
            chk("done_pulse", int'(done), 1);
            chk("done_busy", int'(busy), 0);
            chk("done_valid", int'(out_valid), 0);
            @(posedge clk); #1;
            chk("done_clear", int'(done), 0);
        end
        chk("err_clear", int'(err), 0);
        @(posedge clk); #1;
        chk("queue_drained", q.size(), 0);
    endtask

    initial begin
        rst       = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        dir       = 1'b0;
        start_val = '0;
        len       = '0;
        out_ready = 1'b0;
        #12;
        chk("reset_valid", int'(out_valid), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_wrap", int'(wrap), 0);
        chk("reset_err", int'(err), 0);
        chk("reset_bin", int'(out_bin), 0);
        chk("reset_gray", int'(out_gray), 0);
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_after_reset", int'(out_valid), 0);

        run_seq(0, 0, 1'b0, 0, 0, 0, 0, 0, 1'b0);
        run_seq(5, 4, 1'b1, 0, 0, 0, 0, 0, 1'b0);
        run_seq(2, 3, 1'b0, 2, 3, 0, 0, 0, 1'b0);
        run_seq(1, 6, 1'b0, 0, 0, 3, 0, 0, 1'b0);
        run_seq(4, 5, 1'b0, 0, 0, 0, 2, 0, 1'b0);
        run_seq(6, 7, 1'b1, 0, 0, 0, 0, 4, 1'b0);

        // start together with abort in IDLE must not launch
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort_idle_valid", int'(out_valid), 0);
        chk("start_abort_idle_busy", int'(busy), 0);

        for (int i = 0; i < 10; i++) begin
            run_seq(int'($urandom_range(0, N - 1)), int'($urandom_range(0, N - 1)),
                    1'($urandom_range(0, 1)), 0, 0, 0, 0, 0, 1'b1);
        end

`ifdef GRAY_SEQ_CHECK_EN
        mon_en    = 1'b0;
        out_ready = 1'b1;
        start     = 1'b1;
        start_val = '0;
        len       = '0;
        dir       = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        force dut.out_gray = 3'b111;
        @(posedge clk); #1;
        release dut.out_gray;
        chk("chk_err_set", int'(err), 1);
        repeat (2) @(posedge clk);
        #1;
        chk("chk_err_sticky", int'(err), 1);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("chk_err_after_abort", int'(err), 1);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("chk_err_cleared", int'(err), 0);
        abort = 1'b1;
        @(posedge clk); #1;
        abort  = 1'b0;
        @(posedge clk); #1;
        mon_en = 1'b1;
`endif

        chk("final_queue_empty", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
